// File: rtl/keypad_scanner_if.sv
// Bundles the keypad pins and the key-code delivery register between the
// scanner (master) and the keypad/consumer side (slave).
interface keypad_scanner_if;
    // Delivery: key_valid rises with a new code in key and holds it until a
    // cycle with key_ack=1; key_ack is ignored while key_valid=0.
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       overrun;

    modport master (
        input  col, key_ack,
        output row, key, key_valid, key_held, overrun
    );

    modport slave (
        output col, key_ack,
        input  row, key, key_valid, key_held, overrun
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot row drive, 2-flop column synchronizer,
// press/release debounce and a valid/ack register for the decoded key code.
module keypad_scanner #(
    parameter int SCAN_DIV   = 16,
    parameter int DEB_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  bus,
    output logic [1:0]        o_dbg_state
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_col_m;
    logic [3:0]    r_col_s;
    logic [DW-1:0] r_dwell;
    logic [CW-1:0] r_deb;
    logic [3:0]    r_row;
    logic [1:0]    r_row_idx;
    logic [3:0]    r_col_lat;
    logic [3:0]    r_key;
    logic          r_key_valid;
    logic          r_key_held;
    logic          r_overrun;

    logic          w_rotate;
    logic          w_latch;
    logic          w_emit;
    logic          w_deb_inc;
    logic          w_deb_clr;
    logic          w_dwell_inc;
    logic          w_dwell_clr;
    logic [1:0]    w_row_idx;
    logic [1:0]    w_col_idx;
    logic          w_load;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_SCAN;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_rotate    = 1'b0;
        w_latch     = 1'b0;
        w_emit      = 1'b0;
        w_deb_inc   = 1'b0;
        w_deb_clr   = 1'b0;
        w_dwell_inc = 1'b0;
        w_dwell_clr = 1'b0;
        case (r_state)
            S_SCAN: begin
                if (r_dwell != DWELL_LAST) begin
                    w_dwell_inc = 1'b1;
                end else if (r_col_s == 4'b0) begin
                    w_rotate    = 1'b1;
                    w_dwell_clr = 1'b1;
                end else begin
                    w_latch   = 1'b1;
                    w_deb_clr = 1'b1;
                    w_next    = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                // A change in the latched pattern abandons the press silently.
                if (r_col_s != r_col_lat) begin
                    w_rotate    = 1'b1;
                    w_dwell_clr = 1'b1;
                    w_next      = S_SCAN;
                end else if (r_deb == DEB_LAST) begin
                    w_emit = 1'b1;
                    w_next = S_HELD;
                end else begin
                    w_deb_inc = 1'b1;
                end
            end
            S_HELD: begin
                if (r_col_s == 4'b0) begin
                    w_deb_clr = 1'b1;
                    w_next    = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (r_col_s != 4'b0) begin
                    w_next = S_HELD;
                end else if (r_deb == DEB_LAST) begin
                    w_rotate    = 1'b1;
                    w_dwell_clr = 1'b1;
                    w_next      = S_SCAN;
                end else begin
                    w_deb_inc = 1'b1;
                end
            end
            default: w_next = S_SCAN;
        endcase
    end

    // Lowest set column wins; row is one-hot so any set bit gives its index.
    always_comb begin
        w_col_idx = 2'd0;
        w_row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_col_lat[i]) w_col_idx = 2'(i);
            if (r_row[i])     w_row_idx = 2'(i);
        end
        w_load = w_emit && (!r_key_valid || bus.key_ack);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_m     <= 4'b0;
            r_col_s     <= 4'b0;
            r_dwell     <= '0;
            r_deb       <= '0;
            r_row       <= 4'b0001;
            r_row_idx   <= 2'd0;
            r_col_lat   <= 4'b0;
            r_key       <= 4'b0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_col_m <= bus.col;
            r_col_s <= r_col_m;
            if (w_dwell_clr)      r_dwell <= '0;
            else if (w_dwell_inc) r_dwell <= r_dwell + 1'b1;
            if (w_deb_clr)        r_deb <= '0;
            else if (w_deb_inc)   r_deb <= r_deb + 1'b1;
            if (w_rotate)         r_row <= {r_row[2:0], r_row[3]};
            if (w_latch) begin
                r_row_idx <= w_row_idx;
                r_col_lat <= r_col_s;
            end
            // A new emit in the ack cycle replaces the code instead of clearing valid.
            if (w_load) begin
                r_key       <= {r_row_idx, w_col_idx};
                r_key_valid <= 1'b1;
            end else if (bus.key_ack) begin
                r_key_valid <= 1'b0;
            end
            r_overrun  <= w_emit && r_key_valid && !bus.key_ack;
            r_key_held <= (w_next == S_HELD) || (w_next == S_RELEASE);
        end
    end

    always_comb begin
        bus.row       = r_row;
        bus.key       = r_key;
        bus.key_valid = r_key_valid;
        bus.key_held  = r_key_held;
        bus.overrun   = r_overrun;
        o_dbg_state   = r_state;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives col from row, tasks press
// keys and check codes and timings derived from the scan/debounce rules.
module tb_keypad_scanner;
    localparam int SCAN_DIV   = 4;
    localparam int DEB_CYCLES = 8;
    localparam int PRESS_LAT  = SCAN_DIV + DEB_CYCLES + 1;
    localparam int REL_LAT    = DEB_CYCLES + 4;

    logic        clk;
    logic        rst;
    logic [1:0]  dbg_state;
    logic [15:0] pressed;
    logic        bounce;
    logic [3:0]  kp_col;
    logic [3:0]  exp_q[$];
    int          tests_run;
    int          tests_failed;

    keypad_scanner_if bus();

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a pressed key connects its row line to its column line.
    always_comb begin
        kp_col = 4'b0;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (pressed[rr*4+cc] && bus.row[rr]) kp_col[cc] = 1'b1;
        if (bounce) kp_col = 4'b0;
    end
    assign bus.col = kp_col;

    function automatic logic [3:0] model_key(input int r, input logic [3:0] m);
        for (int c = 0; c < 4; c++)
            if (m[c]) return 4'(r * 4 + c);
        return 4'd0;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_keys(input int r, input logic [3:0] m);
        pressed = 16'b0;
        pressed[r*4 +: 4] = m;
    endtask

    task automatic wait_row(input int r);
        int n;
        n = 0;
        while (bus.row == 4'(1 << r) && n < 64) begin step(); n++; end
        while (bus.row != 4'(1 << r) && n < 128) begin step(); n++; end
        tests_run++;
        if (bus.row != 4'(1 << r)) begin
            tests_failed++;
            $display("FAIL wait_row: row=%b required=%b", bus.row, 4'(1 << r));
        end
    endtask

    task automatic wait_held_low();
        int n;
        n = 0;
        while (bus.key_held && n < 64) begin step(); n++; end
        tests_run++;
        if (bus.key_held !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_held_low: key_held=%b required=0", bus.key_held);
        end
    endtask

    // Press keys m on row r at the start of its dwell, check emit, ack, release.
    task automatic press_cycle(input int r, input logic [3:0] m, input int ack_dly);
        int         lat;
        bit         frozen;
        bit         stable;
        logic [3:0] row_exp;
        logic [3:0] exp_key;
        row_exp = 4'(1 << r);
        exp_q.push_back(model_key(r, m));
        wait_row(r);
        set_keys(r, m);
        lat = 0;
        frozen = 1'b1;
        while (!bus.key_valid && lat < 64) begin
            step();
            lat++;
            if (bus.row !== row_exp) frozen = 1'b0;
        end
        exp_key = exp_q.pop_front();
        tests_run++;
        if (lat != PRESS_LAT) begin
            tests_failed++;
            $display("FAIL press_latency r=%0d m=%b: got %0d required %0d", r, m, lat, PRESS_LAT);
        end
        tests_run++;
        if (bus.key !== exp_key) begin
            tests_failed++;
            $display("FAIL key_code r=%0d m=%b: got %0d required %0d", r, m, bus.key, exp_key);
        end
        tests_run++;
        if (bus.key_held !== 1'b1 || !frozen) begin
            tests_failed++;
            $display("FAIL held_frozen: key_held=%b frozen=%b required 1/1", bus.key_held, frozen);
        end
        stable = 1'b1;
        for (int i = 0; i < ack_dly; i++) begin
            step();
            if (bus.key !== exp_key || bus.key_valid !== 1'b1 || bus.overrun !== 1'b0) stable = 1'b0;
        end
        tests_run++;
        if (!stable) begin
            tests_failed++;
            $display("FAIL key_stable: key=%0d valid=%b required %0d/1", bus.key, bus.key_valid, exp_key);
        end
        bus.key_ack = 1'b1;
        step();
        bus.key_ack = 1'b0;
        tests_run++;
        if (bus.key_valid !== 1'b0 || bus.key_held !== 1'b1) begin
            tests_failed++;
            $display("FAIL ack_clear: valid=%b held=%b required 0/1", bus.key_valid, bus.key_held);
        end
        pressed = 16'b0;
        lat = 0;
        while (bus.key_held && lat < 64) begin step(); lat++; end
        tests_run++;
        if (lat != REL_LAT || bus.row !== 4'(1 << ((r + 1) % 4))) begin
            tests_failed++;
            $display("FAIL release: lat=%0d row=%b required %0d/%b", lat, bus.row, REL_LAT,
                     4'(1 << ((r + 1) % 4)));
        end
    endtask

    task automatic test_reset();
        bit ok;
        step();
        tests_run++;
        if (bus.row !== 4'b0001 || bus.key !== 4'd0 || bus.key_valid !== 1'b0 ||
            bus.key_held !== 1'b0 || bus.overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: row=%b key=%0d v=%b h=%b o=%b required 0001/0/0/0/0",
                     bus.row, bus.key, bus.key_valid, bus.key_held, bus.overrun);
        end
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 8 * SCAN_DIV; i++) begin
            tests_run++;
            if (bus.row !== 4'(1 << ((i / SCAN_DIV) % 4)) || bus.key_valid || bus.key_held) begin
                tests_failed++;
                $display("FAIL idle_scan i=%0d: row=%b v=%b h=%b required %b/0/0", i, bus.row,
                         bus.key_valid, bus.key_held, 4'(1 << ((i / SCAN_DIV) % 4)));
            end
            step();
        end
    endtask

    task automatic test_press_release();
        press_cycle(1, 4'b0100, 3);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++)
            press_cycle(int'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), int'($urandom_range(0, 5)));
    endtask

    task automatic test_bounce();
        int         r;
        int         c;
        int         rises;
        int         ovs;
        logic       prev;
        logic [3:0] exp_key;
        r = int'($urandom_range(0, 3));
        c = int'($urandom_range(0, 3));
        exp_q.push_back(model_key(r, 4'(1 << c)));
        wait_row(r);
        set_keys(r, 4'(1 << c));
        repeat (6) step();
        bounce = 1'b1;
        step();
        bounce = 1'b0;
        repeat (3) step();
        tests_run++;
        if (bus.row !== 4'(1 << ((r + 1) % 4)) || bus.key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_abort: row=%b valid=%b required %b/0", bus.row, bus.key_valid,
                     4'(1 << ((r + 1) % 4)));
        end
        rises = 0;
        ovs = 0;
        prev = bus.key_valid;
        for (int i = 0; i < 120; i++) begin
            step();
            if (bus.key_valid && !prev) rises++;
            if (bus.overrun) ovs++;
            prev = bus.key_valid;
        end
        exp_key = exp_q.pop_front();
        tests_run++;
        if (rises != 1 || ovs != 0 || bus.key !== exp_key) begin
            tests_failed++;
            $display("FAIL bounce_emit_once: rises=%0d overruns=%0d key=%0d required 1/0/%0d",
                     rises, ovs, bus.key, exp_key);
        end
        bus.key_ack = 1'b1;
        step();
        bus.key_ack = 1'b0;
        pressed = 16'b0;
        wait_held_low();
    endtask

    task automatic test_overrun();
        int  n;
        int  ovs;
        bit  key_kept;
        wait_row(0);
        set_keys(0, 4'b0001);
        n = 0;
        while (!bus.key_valid && n < 64) begin step(); n++; end
        pressed = 16'b0;
        wait_held_low();
        wait_row(3);
        set_keys(3, 4'b1000);
        ovs = 0;
        key_kept = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.overrun) ovs++;
            if (bus.key !== 4'd0 || bus.key_valid !== 1'b1) key_kept = 1'b0;
        end
        tests_run++;
        if (ovs != 1 || !key_kept || bus.key_held !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun: pulses=%0d key_kept=%b held=%b required 1/1/1", ovs, key_kept,
                     bus.key_held);
        end
        pressed = 16'b0;
        wait_held_low();
        wait_row(3);
        set_keys(3, 4'b1000);
        repeat (PRESS_LAT - 1) step();
        bus.key_ack = 1'b1;
        step();
        bus.key_ack = 1'b0;
        tests_run++;
        if (bus.key !== 4'd15 || bus.key_valid !== 1'b1 || bus.overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL ack_with_emit: key=%0d valid=%b overrun=%b required 15/1/0", bus.key,
                     bus.key_valid, bus.overrun);
        end
        step();
        tests_run++;
        if (bus.overrun !== 1'b0 || bus.key !== 4'd15) begin
            tests_failed++;
            $display("FAIL ack_with_emit_after: overrun=%b key=%0d required 0/15", bus.overrun, bus.key);
        end
        bus.key_ack = 1'b1;
        step();
        bus.key_ack = 1'b0;
        pressed = 16'b0;
        wait_held_low();
    endtask

    task automatic test_multi_column();
        press_cycle(3, 4'b1010, 1);
    endtask

    task automatic test_reset_in_held();
        int n;
        bit ok;
        wait_row(2);
        set_keys(2, 4'b0010);
        n = 0;
        while (!bus.key_valid && n < 64) begin step(); n++; end
        repeat (3) step();
        rst = 1'b1;
        step();
        tests_run++;
        if (bus.row !== 4'b0001 || bus.key !== 4'd0 || bus.key_valid !== 1'b0 ||
            bus.key_held !== 1'b0 || bus.overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_held: row=%b key=%0d v=%b h=%b o=%b required 0001/0/0/0/0",
                     bus.row, bus.key, bus.key_valid, bus.key_held, bus.overrun);
        end
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i <= 2 * SCAN_DIV; i++) begin
            if (bus.row !== 4'(1 << (i / SCAN_DIV))) ok = 1'b0;
            step();
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL restart_scan: row=%b required sweep from 0001", bus.row);
        end
        pressed = 16'b0;
        repeat (20) step();
        tests_run++;
        if (bus.key_valid !== 1'b0 || bus.key_held !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: valid=%b held=%b required 0/0", bus.key_valid, bus.key_held);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        pressed = 16'b0;
        bounce = 1'b0;
        bus.key_ack = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_press_release();
        test_random();
        test_bounce();
        test_overrun();
        test_multi_column();
        test_reset_in_held();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Controller for a 4x4 active-high matrix keypad. It drives the rows one-hot in turn and synchronizes the column lines. When a column is high, it freezes the scan and debounces the row/column hit, then releases a 4-bit key code through a valid/ack register. It sits between the keypad pins and the input-decoding logic, replacing per-button debouncing for matrix keypads.

## Interface
Parameters:
- SCAN_DIV, 16: clocks each row is driven before its columns are sampled; must be ≥ 4.
- DEB_CYCLES, 8: consecutive stable synchronized samples required for press and for release; must be ≥ 1.

Ports:
- clk  in  1  system clock; the block uses one clock only.
- rst  in  1  reset, synchronous and active-high.
- col  in  4  raw column lines; active-high, asynchronous.
- row  out 4  row drive, one-hot.
- key  out 4  key code = row_index*4 + col_index.
- key_valid  out 1  a key code is pending; held until acked.
- key_ack  in  1  consumer accepts `key`; ignored while key_valid=0.
- key_held  out 1  high while the FSM is in HELD or RELEASE.
- overrun  out 1  one-cycle pulse: a press completed while the previous code was still pending.

## Operation
- Synchronizer:
  - `col` passes through 2 flops to give col_s.
  - All decisions use col_s only.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - The dwell counter (width clog2(SCAN_DIV)) counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1 the FSM samples col_s.
  - If col_s == 0: `row` rotates left (0001→0010→0100→1000→0001) and the dwell counter resets to 0.
  - If col_s != 0: latch row_index and col_s into col_lat, clear deb_cnt, go to DEBOUNCE. `row` does not rotate.
- DEBOUNCE:
  - `row` stays frozen.
  - Each cycle, if col_s == col_lat, increment deb_cnt (width clog2(DEB_CYCLES+1)).
  - If col_s != col_lat, rotate `row`, clear the dwell counter, and go to SCAN; no key is emitted.
  - When deb_cnt reaches DEB_CYCLES, emit the key and go to HELD.
- Key emit:
  - col_index is the lowest set bit of col_lat (lowest index wins on multi-column presses).
  - If key_valid=0, or key_ack=1 in the same cycle: load `key` and set key_valid=1.
  - Otherwise keep the old `key` and pulse overrun for one cycle.
- HELD:
  - `row` stays frozen.
  - When col_s == 0, clear deb_cnt and go to RELEASE.
- RELEASE:
  - Each cycle, if col_s == 0, increment deb_cnt.
  - If col_s != 0, go back to HELD; a held key is never re-emitted.
  - When deb_cnt reaches DEB_CYCLES, rotate `row`, clear the dwell counter, and go to SCAN.
- Handshake:
  - key_valid clears on a cycle with key_ack=1, unless a new emit occurs in that same cycle, in which case it stays 1 and `key` takes the new code.
  - `key` is stable while key_valid=1.
- Presses on other rows while frozen are not seen until SCAN resumes.

## Timing
- Reset values: state=SCAN, row=4'b0001, dwell=0, deb_cnt=0, key=0, key_valid=0, key_held=0, overrun=0. Synchronizer flops are also cleared.
- Reset asserted mid-operation aborts any state and drops key_valid the next cycle.
- SCAN_DIV ≥ 4 guarantees the col_s sample reflects the currently driven row: 2 cycles of synchronizer latency plus settle time.
- Scan period with no key pressed: 4*SCAN_DIV cycles per full sweep.
- key_valid rises DEB_CYCLES+1 cycles after the cycle the FSM entered DEBOUNCE, given stable input.
- key_held rises the same cycle key_valid rises on an accepted emit. It falls the cycle RELEASE completes.
- Earliest next scan sample after release: SCAN_DIV cycles after leaving RELEASE.
- All outputs are registered; no combinational path from col or key_ack to any output.

## Test plan
1. Reset with col=0, bench parameters SCAN_DIV=4, DEB_CYCLES=8:
   - row goes 0001→0010→0100→1000→0001, 4 cycles per row.
   - key_valid and key_held stay 0.
2. Hold col=4'b0100 while row=0010, then release:
   - row freezes at 0010.
   - key=6 and key_valid=1 after the debounce period; key_held=1.
   - After ack, key_valid=0.
   - After release plus 8 clean cycles, scan resumes at row=0100.
3. Bounce col=0100 off for 1 cycle during DEBOUNCE:
   - Returns to SCAN with no key_valid.
   - A subsequent stable press emits exactly once.
4. Press key 0, leave it unacked, release, then press key 15:
   - key stays 0 and overrun pulses once.
   - Acking the next press with key_ack and emit in the same cycle loads 15 with key_valid kept at 1.
5. Press col=4'b1010 on row 1000: key=13 (lowest set column wins).
6. Assert rst during HELD with key_valid=1:
   - The next cycle shows all reset values.
   - Scan restarts at 0001 even while the key is still pressed.
